// File: rtl/ram1_arbiter.sv
// ram1_arbiter: sequencer/arbiter for the single-port RAM1 SRAM shared by the
// instruction-fetch port and the MEM-stage port. One access at a time runs
// IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> RECOVER (ack cycle) -> IDLE.
// Optional feature macro: RAM1_ARB_FAIR_EN. When defined, contended grants
// alternate between ports by a last-grant flag. When undefined, MEM always
// beats IF.
module ram1_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_ack,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ack,
  output logic        stallreq,
  output logic        ram_ce,
  output logic        ram_re,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_mem_q, gnt_mem_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        ram_ce_q, ram_ce_d;
  logic        ram_re_q, ram_re_d;
  logic        ram_we_q, ram_we_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic        pick_mem;
`ifdef RAM1_ARB_FAIR_EN
  logic        last_mem_q, last_mem_d;
`endif

  // Arbitration: which port would win if a grant were made this cycle.
  always_comb begin
`ifdef RAM1_ARB_FAIR_EN
    // Under contention the port that did not win last time goes first.
    pick_mem = mem_req & (~if_req | ~last_mem_q);
`else
    pick_mem = mem_req;
`endif
  end

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_mem_d   = gnt_mem_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    ram_ce_d    = ram_ce_q;
    ram_re_d    = ram_re_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
`ifdef RAM1_ARB_FAIR_EN
    last_mem_d  = last_mem_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (if_req || mem_req) begin
          // The RAM output registers double as the latched request, so the
          // bus stays stable for the whole access regardless of the inputs.
          state_d     = ST_ACCESS;
          cnt_d       = WAIT_LD;
          gnt_mem_d   = pick_mem;
          ram_ce_d    = 1'b1;
          ram_we_d    = pick_mem & mem_we;
          ram_re_d    = ~(pick_mem & mem_we);
          ram_addr_d  = pick_mem ? mem_addr : if_addr;
          ram_wdata_d = pick_mem ? mem_wdata : 32'd0;
`ifdef RAM1_ARB_FAIR_EN
          last_mem_d  = pick_mem;
`endif
        end
      end

      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d     = ST_RECOVER;
          ram_ce_d    = 1'b0;
          ram_re_d    = 1'b0;
          ram_we_d    = 1'b0;
          ram_addr_d  = 32'd0;
          ram_wdata_d = 32'd0;
          if (gnt_mem_q) begin
            mem_ack_d = 1'b1;
            if (ram_re_q) begin
              mem_rdata_d = ram_rdata;
            end
          end else begin
            if_ack_d = 1'b1;
            if (ram_re_q) begin
              if_data_d = ram_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_RECOVER: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset returns to IDLE and suppresses any ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      gnt_mem_q   <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      ram_ce_q    <= 1'b0;
      ram_re_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= 32'd0;
      ram_wdata_q <= 32'd0;
`ifdef RAM1_ARB_FAIR_EN
      last_mem_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_mem_q   <= gnt_mem_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      ram_ce_q    <= ram_ce_d;
      ram_re_q    <= ram_re_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
`ifdef RAM1_ARB_FAIR_EN
      last_mem_q  <= last_mem_d;
`endif
    end
  end

  assign if_data   = if_data_q;
  assign if_ack    = if_ack_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_ack   = mem_ack_q;
  assign ram_ce    = ram_ce_q;
  assign ram_re    = ram_re_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign stallreq  = (if_req & ~if_ack_q) | (mem_req & ~mem_ack_q);

endmodule

// File: doc/ram1_arbiter.md
# ram1_arbiter

Sequencer and arbiter for the single-port RAM1 SRAM shared by instruction fetch (IF) and the MEM stage. Accepts level requests from both ports, grants one at a time, and drives the RAM chip/read/write enables through a fixed multi-cycle access with a recovery cycle. Returns registered read data with a one-cycle ack pulse. Raises `stallreq` to the pipeline controller while any request is outstanding.

## Interface

Parameters:
- `WAIT_CYCLES`, default 1: extra cycles the RAM enables are held beyond the first ACCESS cycle; legal range 0..15.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `if_req`  in  1  IF read request, level; held until `if_ack`.
- `if_addr`  in  32  IF word address.
- `if_data`  out  32  IF read data, registered.
- `if_ack`  out  1  one-cycle pulse, IF access complete.
- `mem_req`  in  1  MEM request, level; held until `mem_ack`.
- `mem_we`  in  1  1 = write, 0 = read.
- `mem_addr`  in  32  MEM word address.
- `mem_wdata`  in  32  MEM write data.
- `mem_rdata`  out  32  MEM read data, registered.
- `mem_ack`  out  1  one-cycle pulse, MEM access complete.
- `stallreq`  out  1  `(if_req & ~if_ack) | (mem_req & ~mem_ack)`, combinational.
- `ram_ce`  out  1  RAM chip enable, active high.
- `ram_re`  out  1  RAM read enable, active high.
- `ram_we`  out  1  RAM write enable, active high.
- `ram_addr`  out  32  RAM address; only bits [11:0] are decoded by RAM1.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data.

## Operation

- FSM states: IDLE, ACCESS, RECOVER.
- IDLE:
  - If any request is pending, grant one port.
  - Latch the granted address; for MEM, also latch `mem_we` and `mem_wdata`.
  - Load counter with `WAIT_CYCLES` and go to ACCESS.
  - With no request, stay in IDLE.
- Grant rule when both requests are pending: MEM wins (see Configuration). A single pending request is always granted.
- ACCESS:
  - `ram_ce`=1. Assert `ram_re` for reads or `ram_we` for writes.
  - `ram_addr` and `ram_wdata` are driven from the latched values and are stable for the whole state.
  - The counter decrements each cycle.
  - In the cycle the counter reads 0:
    - For reads, capture `ram_rdata` into `if_data` or `mem_rdata`.
    - Set the granted port's ack for the next cycle.
    - Go to RECOVER.
- RECOVER:
  - All RAM enables are 0.
  - Ack is high for this one cycle.
  - Go to IDLE unconditionally.
- Outside ACCESS: `ram_ce`/`ram_re`/`ram_we`=0, `ram_addr`/`ram_wdata`=0.
- A request observed in the cycle after its ack is a new request; the pipeline advances on the ack cycle.
- Writes leave `mem_rdata` unchanged. Read data registers hold their value until the next read completes on the same port.
- Changes to the inputs of a granted port during ACCESS are ignored.

## Timing

- Reset values:
  - state IDLE, counter 0.
  - `if_data`=0, `mem_rdata`=0.
  - `if_ack`=0, `mem_ack`=0.
  - `ram_ce`/`ram_re`/`ram_we`=0, `ram_addr`=0, `ram_wdata`=0.
  - fairness flag=0.
- Access latency:
  - Request first seen in IDLE at cycle 0.
  - ACCESS occupies cycles 1..WAIT_CYCLES+1.
  - Ack is high in cycle WAIT_CYCLES+2.
  - Next grant is possible at cycle WAIT_CYCLES+3.
- Back-to-back throughput: one access per WAIT_CYCLES+3 cycles.
- `rst` mid-ACCESS: at the next edge the FSM returns to IDLE, enables drop, and no ack is issued. A partially written word is undefined.
- `rst` has priority over all other events.
- Both requests arriving while the FSM is busy: evaluated in the next IDLE cycle.

## Configuration

- `RAM1_ARB_FAIR_EN` defined:
  - A 1-bit last-grant flag is updated at every grant.
  - When both requests are pending, the port NOT granted last wins.
  - `rst` clears the flag, so MEM wins the first contended grant.
- Undefined: fixed priority, MEM always beats IF; no flag register is present.

## Test plan

- Reset, IF read with no contention: preload RAM[0x004]=0x12345678, WAIT_CYCLES=1, `if_req`=1 with `if_addr`=0x4 at cycle 0. Required: `ram_re` high in cycles 1–2, `if_ack` high only in cycle 3, `if_data`=0x12345678, `stallreq` high in cycles 0–2 and low in cycle 3.
- MEM write then read: write 0xDEADBEEF to 0x010, then read 0x010. Required:
  - Write: `ram_we` high for 2 cycles, `mem_rdata` unchanged.
  - Read: `mem_rdata`=0xDEADBEEF.
  - Acks 4 cycles apart.
- Simultaneous requests with IF=0x000 and MEM=0x008:
  - Fixed mode: MEM acked in cycle 3, IF acked in cycle 7.
  - With `RAM1_ARB_FAIR_EN` and both held continuously with new addresses: grants alternate MEM, IF, MEM, IF.
- Reset mid-access: assert `rst` in cycle 2 of an IF read. Required: all RAM enables 0 in cycle 3, no `if_ack`, `if_data`=0.
- WAIT_CYCLES=0 and WAIT_CYCLES=3: the ack arrives at cycle 2 and cycle 5 respectively, and `ram_addr` is stable for the whole ACCESS.
